// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receive front end: conditions the raw PS/2 lines, deserialises
// 11-bit frames, assembles 3-byte stream packets and keeps a clamped absolute
// pointer position plus button state.
module ps2_mouse_tracker #(
  parameter int MAX_X          = 799,
  parameter int MAX_Y          = 599,
  parameter int INIT_X         = 400,
  parameter int INIT_Y         = 300,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] mouse_x_position,
  output logic [11:0] mouse_y_position,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        packet_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2, P_UPDATE} pkt_state_t;

  // Status-byte fields that the position update actually uses.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic right;
    logic left;
  } status_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          clk_filt, filt_flip, fall_edge;
  logic [FW-1:0] filt_cnt;

  frame_state_t  f_state, f_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_expire, byte_valid, err_now;

  pkt_state_t    p_state, p_next;
  status_t       status_r;
  logic [7:0]    dx_r, dy_r;
  logic signed [13:0] dx_ext, dy_ext, sum_x, sum_y;
  logic [11:0]   next_x, next_y;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronisers; idle PS/2 lines are high.
  // NOTE: clocked state uses <= so every flop samples pre-edge values and
  // simulation ordering between always_ff blocks cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock flips once the new level has held FILTER_LEN cycles.
  assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall_edge = filt_flip && clk_filt;

  // Glitch filter on the synchronised PS/2 clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // An edge always reloads the timer, so expiry only fires on a quiet line.
  assign tmo_expire = (f_state != F_IDLE) && !fall_edge &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign byte_valid = fall_edge && (f_state == F_STOP) && data_s &&
                      (^{shift_reg, par_bit});
  assign err_now    = tmo_expire ||
                      (fall_edge && (f_state == F_STOP) && !byte_valid);

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) f_state <= F_IDLE;
    else     f_state <= f_next;
  end

  // Frame FSM next state: start bit, 8 data bits, parity, stop.
  // NOTE: f_next gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    f_next = f_state;
    if (tmo_expire) begin
      f_next = F_IDLE;
    end else if (fall_edge) begin
      unique case (f_state)
        F_IDLE:   if (!data_s) f_next = F_DATA;
        F_DATA:   if (bit_cnt == 3'd7) f_next = F_PARITY;
        F_PARITY: f_next = F_STOP;
        F_STOP:   f_next = F_IDLE;
        default:  f_next = F_IDLE;
      endcase
    end
  end

  // Frame datapath: bit shifting, parity capture, timeout and error pulse.
  // NOTE: datapath registers are reset along with the control state so the
  // clamp arithmetic never sees X in simulation after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_now;
      if (f_state == F_IDLE || fall_edge) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;
      if (fall_edge) begin
        unique case (f_state)
          F_IDLE:   bit_cnt <= '0;
          F_DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          F_PARITY: par_bit <= data_s;
          default:  ;
        endcase
      end
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (rst) p_state <= P_BYTE0;
    else     p_state <= p_next;
  end

  // Packet FSM next state; any frame error resynchronises to BYTE0.
  always_comb begin
    p_next = p_state;
    if (err_now) begin
      p_next = P_BYTE0;
    end else begin
      unique case (p_state)
        P_BYTE0:  if (byte_valid && shift_reg != 8'hFA && shift_reg[3]) p_next = P_BYTE1;
        P_BYTE1:  if (byte_valid) p_next = P_BYTE2;
        P_BYTE2:  if (byte_valid) p_next = P_UPDATE;
        P_UPDATE: p_next = P_BYTE0;
        default:  p_next = P_BYTE0;
      endcase
    end
  end

  // Capture status and delta bytes as the packet FSM advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= '0;
      dx_r     <= '0;
      dy_r     <= '0;
    end else if (byte_valid) begin
      if (p_state == P_BYTE0 && p_next == P_BYTE1)
        status_r <= '{y_ovf: shift_reg[7], x_ovf: shift_reg[6], y_sign: shift_reg[5],
                      x_sign: shift_reg[4], right: shift_reg[1], left: shift_reg[0]};
      if (p_state == P_BYTE1) dx_r <= shift_reg;
      if (p_state == P_BYTE2) dy_r <= shift_reg;
    end
  end

  // Signed 9-bit deltas widened to 14 bits; PS/2 +y is up, screen +y is down.
  always_comb begin
    dx_ext = status_r.x_ovf ? 14'sd0 : {{6{status_r.x_sign}}, dx_r};
    dy_ext = status_r.y_ovf ? 14'sd0 : {{6{status_r.y_sign}}, dy_r};
    sum_x  = $signed({2'b00, mouse_x_position}) + dx_ext;
    sum_y  = $signed({2'b00, mouse_y_position}) - dy_ext;
    if (sum_x < 0)          next_x = '0;
    else if (sum_x > MAX_X) next_x = 12'(MAX_X);
    else                    next_x = sum_x[11:0];
    if (sum_y < 0)          next_y = '0;
    else if (sum_y > MAX_Y) next_y = 12'(MAX_Y);
    else                    next_y = sum_y[11:0];
  end

  // Output registers: updated only in UPDATE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_x_position <= 12'(INIT_X);
      mouse_y_position <= 12'(INIT_Y);
      mouse_left       <= 1'b0;
      mouse_right      <= 1'b0;
      packet_valid     <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      if (p_state == P_UPDATE && !err_now) begin
        mouse_x_position <= next_x;
        mouse_y_position <= next_y;
        mouse_left       <= status_r.left;
        mouse_right      <= status_r.right;
        packet_valid     <= 1'b1;
      end
    end
  end

endmodule
